// File: rtl/arith_result_buffer.sv
// arith_result_buffer: first-word-fall-through result FIFO behind the ALU.
// Captures every o_result/o_status pair the ALU emits and presents the head on
// a valid/ready drain port. It never stalls the producer: a push into a full
// FIFO with no pop is dropped and counted. Sticky status and overflow flags
// summarise traffic since the last i_clear.
module arith_result_buffer #(
  parameter int BITS   = 32,
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_valid,
  input  logic [BITS-1:0]          i_result,
  input  logic [3:0]               i_status,
  input  logic                     i_ready,
  input  logic                     i_clear,
  output logic                     o_valid,
  output logic [BITS-1:0]          o_result,
  output logic [3:0]               o_status,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic [3:0]               o_sticky_status,
  output logic                     o_overflow,
  output logic [DROP_W-1:0]        o_drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = BITS + 4;
  localparam logic [CW-1:0]     DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [PW-1:0]     PTR_ONE  = PW'(1);
  localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

  // Storage: {status, result} per entry, no reset needed because the
  // pointers and count define which entries are meaningful.
  logic [EW-1:0]     ram_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;

  logic              full_s;
  logic              pop_s;
  logic              drop_s;
  logic              push_ok_s;
  logic [PW-1:0]     wr_ptr_nxt_s;
  logic [PW-1:0]     rd_ptr_nxt_s;
  logic [CW-1:0]     count_nxt_s;
  logic [EW-1:0]     head_nxt_s;
  logic [3:0]        sticky_nxt_s;
  logic              overflow_nxt_s;
  logic [DROP_W-1:0] drop_nxt_s;

  // Next-state decode for push/pop/drop, pointers, fill level, head and flags.
  always_comb begin
    full_s       = (o_count == DEPTH_C);
    pop_s        = i_ready & o_valid;
    drop_s       = i_valid & full_s & ~pop_s;
    push_ok_s    = i_valid & ~drop_s;

    if (push_ok_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end

    case ({push_ok_s, pop_s})
      2'b10:   count_nxt_s = o_count + CNT_ONE;
      2'b01:   count_nxt_s = o_count - CNT_ONE;
      default: count_nxt_s = o_count;
    endcase

    // The incoming entry becomes the head when it lands exactly where the
    // read pointer will point (FIFO empty, or its only entry being popped).
    if (push_ok_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = {i_status, i_result};
    end else begin
      head_nxt_s = ram_r[rd_ptr_nxt_s];
    end

    if (i_clear) begin
      sticky_nxt_s   = push_ok_s ? i_status : 4'b0000;
      overflow_nxt_s = drop_s;
      drop_nxt_s     = drop_s ? DROP_ONE : {DROP_W{1'b0}};
    end else begin
      sticky_nxt_s   = push_ok_s ? (o_sticky_status | i_status) : o_sticky_status;
      overflow_nxt_s = o_overflow | drop_s;
      if (drop_s && !(&o_drop_cnt)) begin
        drop_nxt_s = o_drop_cnt + DROP_ONE;
      end else begin
        drop_nxt_s = o_drop_cnt;
      end
    end
  end

  // Write accepted pushes into the circular RAM.
  always_ff @(posedge i_clk) begin
    if (push_ok_s) begin
      ram_r[wr_ptr_r] <= {i_status, i_result};
    end
  end

  // Pointers, fill level, registered head outputs and status flags.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_r        <= {PW{1'b0}};
      rd_ptr_r        <= {PW{1'b0}};
      o_count         <= {CW{1'b0}};
      o_valid         <= 1'b0;
      o_full          <= 1'b0;
      o_result        <= {BITS{1'b0}};
      o_status        <= 4'b0000;
      o_sticky_status <= 4'b0000;
      o_overflow      <= 1'b0;
      o_drop_cnt      <= {DROP_W{1'b0}};
    end else begin
      wr_ptr_r        <= wr_ptr_nxt_s;
      rd_ptr_r        <= rd_ptr_nxt_s;
      o_count         <= count_nxt_s;
      o_valid         <= (count_nxt_s != {CW{1'b0}});
      o_full          <= (count_nxt_s == DEPTH_C);
      // Head holds its last value while the FIFO is empty.
      if (count_nxt_s != {CW{1'b0}}) begin
        o_result <= head_nxt_s[BITS-1:0];
        o_status <= head_nxt_s[EW-1:BITS];
      end else begin
        o_result <= o_result;
        o_status <= o_status;
      end
      o_sticky_status <= sticky_nxt_s;
      o_overflow      <= overflow_nxt_s;
      o_drop_cnt      <= drop_nxt_s;
    end
  end

endmodule
